// File: rtl/fv_fifo_rr_sched.sv
// fv_fifo_rr_sched: round-robin pop scheduler draining several FIFOs onto one valid/ready channel,
// with bounded bursts and a stall HOLD state that keeps the offered transfer stable until accepted.
module fv_fifo_rr_sched #(
    parameter int NumFifos  = 4,
    parameter int DataWidth = 4,
    parameter int MaxBurst  = 1,
    localparam int IdW  = (NumFifos > 1) ? $clog2(NumFifos) : 1,
    localparam int CntW = (MaxBurst > 1) ? $clog2(MaxBurst) : 1
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NumFifos-1:0]           fifo_empty,
    input  logic [NumFifos*DataWidth-1:0] fifo_pop_data,
    output logic [NumFifos-1:0]           fifo_pop,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [DataWidth-1:0]          out_data,
    output logic [IdW-1:0]                out_id
);
    typedef enum logic {ARB, HOLD} state_t;
    state_t fsm, fsm_nxt;
    logic [IdW-1:0] rr_ptr, held_id, grant, scan_id, idx, nxt_ptr;
    logic [CntW-1:0] burst_cnt, eff_cnt;
    logic [DataWidth-1:0] heads [NumFifos];
    logic xfer, last;
    for (genvar g = 0; g < NumFifos; g++) begin : g_heads
        assign heads[g] = fifo_pop_data[g*DataWidth +: DataWidth];
    end
    // Scan from the highest offset down so the entry closest to rr_ptr wins.
    always_comb begin
        scan_id = '0;
        idx = '0;
        for (int k = NumFifos - 1; k >= 0; k--) begin
            idx = IdW'((int'(rr_ptr) + k) % NumFifos);
            if (!fifo_empty[idx]) scan_id = idx;
        end
    end
    always_comb begin
        grant     = (fsm == HOLD) ? held_id : scan_id;
        out_valid = !rst && ((fsm == HOLD) || !(&fifo_empty));
        out_id    = grant;
        out_data  = heads[grant];
        xfer      = out_valid && out_ready;
        fifo_pop  = xfer ? (NumFifos'(1) << grant) : '0;
        fsm_nxt   = (out_valid && !out_ready) ? HOLD : ARB;
        // A grant away from rr_ptr means the burst owner ran dry, so a fresh burst starts.
        eff_cnt   = (grant == rr_ptr) ? burst_cnt : '0;
        last      = eff_cnt == CntW'(MaxBurst - 1);
        nxt_ptr   = (grant == IdW'(NumFifos - 1)) ? '0 : grant + 1'b1;
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fsm       <= ARB;
            rr_ptr    <= '0;
            held_id   <= '0;
            burst_cnt <= '0;
        end else begin
            fsm <= fsm_nxt;
            if (fsm == ARB && fsm_nxt == HOLD) held_id <= grant;
            if (xfer) begin
                rr_ptr    <= last ? nxt_ptr : grant;
                burst_cnt <= last ? '0 : eff_cnt + 1'b1;
            end
        end
    end
`ifndef SYNTHESIS
    localparam int Bound = (NumFifos - 1) * MaxBurst;
    logic [DataWidth-1:0] hold_data;
    int wait_cnt [NumFifos];
    always_ff @(posedge clk) begin
        if (fsm == ARB && fsm_nxt == HOLD) hold_data <= out_data;
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < NumFifos; k++) wait_cnt[k] <= 0;
        end else begin
            assert ($onehot0(fifo_pop)) else $error("fifo_pop not onehot0");
            assert ((fifo_pop & fifo_empty) == '0) else $error("pop of empty fifo");
            if (fsm == HOLD) begin
                assert (!fifo_empty[held_id]) else $error("held fifo went empty");
                assert (out_valid && out_id == held_id && out_data == hold_data) else $error("held channel changed");
            end
            for (int k = 0; k < NumFifos; k++) begin
                if (fifo_empty[k] || fifo_pop[k]) wait_cnt[k] <= 0;
                else if (xfer) begin
                    assert (wait_cnt[k] < Bound) else $error("fairness bound exceeded on fifo %0d", k);
                    wait_cnt[k] <= wait_cnt[k] + 1;
                end
            end
        end
    end
`endif
endmodule

// File: tb/tb_fv_fifo_rr_sched.sv
// tb_fv_fifo_rr_sched: scoreboard bench over three scheduler configurations (4x1, 4x2 burst, 3x1)
// with queue-modelled FIFOs; expected (id, data) grants are queued when stimulus is driven.
module tb_fv_fifo_rr_sched;
    logic clk = 0, rst = 1, ready_t = 0;
    logic [3:0] empty_t = '1;
    logic [15:0] data_t = '0;
    int sel = 0;
    logic [3:0] pop_a, pop_b, da, db, dc, pop, out_data;
    logic [2:0] pop_c;
    logic [1:0] ia, ib, ic, out_id;
    logic va, vb, vc, vld;
    typedef struct {int id; int data;} exp_t;
    exp_t exp_q[$];
    logic [3:0] fq [4][$];
    int n_chk = 0, n_pass = 0;
    int pops_seen [4];
    always #5 clk = ~clk;
    fv_fifo_rr_sched #(.NumFifos(4), .DataWidth(4), .MaxBurst(1)) u_a (
        .clk(clk), .rst(rst), .fifo_empty(sel == 0 ? empty_t : 4'hf), .fifo_pop_data(data_t),
        .fifo_pop(pop_a), .out_valid(va), .out_ready(ready_t && sel == 0), .out_data(da), .out_id(ia));
    fv_fifo_rr_sched #(.NumFifos(4), .DataWidth(4), .MaxBurst(2)) u_b (
        .clk(clk), .rst(rst), .fifo_empty(sel == 1 ? empty_t : 4'hf), .fifo_pop_data(data_t),
        .fifo_pop(pop_b), .out_valid(vb), .out_ready(ready_t && sel == 1), .out_data(db), .out_id(ib));
    fv_fifo_rr_sched #(.NumFifos(3), .DataWidth(4), .MaxBurst(1)) u_c (
        .clk(clk), .rst(rst), .fifo_empty(sel == 2 ? empty_t[2:0] : 3'b111), .fifo_pop_data(data_t[11:0]),
        .fifo_pop(pop_c), .out_valid(vc), .out_ready(ready_t && sel == 2), .out_data(dc), .out_id(ic));
    always_comb begin
        vld      = sel == 0 ? va : sel == 1 ? vb : vc;
        pop      = sel == 0 ? pop_a : sel == 1 ? pop_b : {1'b0, pop_c};
        out_data = sel == 0 ? da : sel == 1 ? db : dc;
        out_id   = sel == 0 ? ia : sel == 1 ? ib : ic;
    end
    task automatic check(input string tag, input int got, input int want);
        n_chk++;
        if (got == want) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", tag, got, want);
    endtask
    task automatic refresh();
        for (int i = 0; i < 4; i++) begin
            empty_t[i] = fq[i].size() == 0;
            data_t[i*4 +: 4] = empty_t[i] ? 4'h0 : fq[i][0];
        end
    endtask
    task automatic push(input int i, input int d);
        fq[i].push_back(4'(d));
        refresh();
    endtask
    task automatic expect_xfer(input int id, input int d);
        exp_t e;
        e.id = id;
        e.data = d;
        exp_q.push_back(e);
    endtask
    task automatic tick();
        exp_t e;
        int popped = -1;
        @(negedge clk);
        for (int i = 0; i < 4; i++) if (pop[i]) pops_seen[i]++;
        if (vld && ready_t) begin
            if (exp_q.size() == 0) check("extra_xfer", 1, 0);
            else begin
                e = exp_q.pop_front();
                check("xfer_id", int'(out_id), e.id);
                check("xfer_data", int'(out_data), e.data);
                check("xfer_pop", int'(pop), 1 << e.id);
                popped = e.id;
            end
        end else check("idle_pop", int'(pop), 0);
        @(posedge clk);
        #1;
        if (popped >= 0 && fq[popped].size() > 0) void'(fq[popped].pop_front());
        refresh();
    endtask
    task automatic drain(input int lim);
        int n = 0;
        while (exp_q.size() > 0 && n < lim) begin
            tick();
            n++;
        end
        check("drain_left", exp_q.size(), 0);
    endtask
    task automatic restart(input int s);
        rst = 1;
        sel = s;
        for (int i = 0; i < 4; i++) fq[i].delete();
        exp_q.delete();
        refresh();
        @(posedge clk);
        #1;
        rst = 0;
    endtask
    initial begin
        for (int k = 0; k < 2; k++)
            for (int i = 0; i < 4; i++) begin
                push(i, i * 4 + k);
                expect_xfer(i, i * 4 + k);
            end
        ready_t = 1;
        @(negedge clk);
        check("rst_valid", int'(vld), 0);
        check("rst_pop", int'(pop), 0);
        @(posedge clk);
        #1;
        rst = 0;
        drain(20);
        push(2, 5); expect_xfer(2, 5); drain(5);
        push(2, 6); expect_xfer(2, 6); drain(5);
        push(3, 7); push(0, 8); expect_xfer(3, 7); expect_xfer(0, 8); drain(5);
        push(3, 9); expect_xfer(3, 9); drain(5);
        ready_t = 0;
        push(1, 10);
        expect_xfer(1, 10);
        tick();
        push(0, 11);
        for (int k = 0; k < 3; k++) begin
            if (k == 1) push(1, 12);
            tick();
            check("hold_valid", int'(vld), 1);
            check("hold_id", int'(out_id), 1);
            check("hold_data", int'(out_data), 10);
        end
        ready_t = 1;
        expect_xfer(0, 11);
        expect_xfer(1, 12);
        drain(6);
        ready_t = 0;
        push(3, 13);
        tick();
        push(0, 14);
        rst = 1;
        @(negedge clk);
        check("rst_hold_valid", int'(vld), 0);
        check("rst_hold_pop", int'(pop), 0);
        @(posedge clk);
        #1;
        rst = 0;
        ready_t = 1;
        expect_xfer(0, 14);
        expect_xfer(3, 13);
        drain(5);
        restart(1);
        for (int k = 0; k < 3; k++) begin
            push(0, 1 + k);
            push(1, 4 + k);
        end
        expect_xfer(0, 1); expect_xfer(0, 2); expect_xfer(1, 4);
        expect_xfer(1, 5); expect_xfer(0, 3); expect_xfer(1, 6);
        drain(10);
        restart(2);
        for (int i = 0; i < 4; i++) pops_seen[i] = 0;
        for (int k = 0; k < 3; k++)
            for (int i = 0; i < 3; i++) begin
                push(i, i * 4 + k);
                expect_xfer(i, i * 4 + k);
            end
        drain(15);
        for (int i = 0; i < 3; i++) check($sformatf("fair_pops%0d", i), pops_seen[i], 3);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/fv_fifo_rr_sched.md
Name: fv_fifo_rr_sched

Overview:
- Round-robin pop scheduler for the formal library.
- Drains NumFifos non-bypass FIFO models onto one valid/ready output channel.
- Provides fair, bounded-latency sharing of a single consumer among several queues.
- Used as an abstract model and as the DUT-side driver in multi-queue FPV testbenches. It sequences each FIFO's pop and never pops an empty queue.

Parameters:
- NumFifos, 4, number of scheduled FIFOs (>=2).
- DataWidth, 4, width of each FIFO's data.
- MaxBurst, 1, maximum consecutive pops granted to one FIFO before the pointer is forced onward (>=1).

Ports:
- clk  input  1  clock.
- rst  input  1  reset; asynchronous, active-high.
- fifo_empty  input  NumFifos  per-FIFO empty flag.
- fifo_pop_data  input  NumFifos*DataWidth  per-FIFO head data; valid when the matching empty flag is 0.
- fifo_pop  output  NumFifos  per-FIFO pop strobe; one-hot or zero.
- out_valid  output  1  output channel valid.
- out_ready  input  1  output channel ready.
- out_data  output  DataWidth  granted FIFO's head data.
- out_id  output  max(1,$clog2(NumFifos))  index of the granted FIFO.

Behaviour:
- State registers:
  - rr_ptr, the highest-priority index.
  - fsm in {ARB, HOLD}.
  - held_id.
  - burst_cnt, range 0..MaxBurst-1.
- Reset values: rr_ptr=0, fsm=ARB, held_id=0, burst_cnt=0.
- While rst is high, fifo_pop=0 and out_valid=0.
- ARB state:
  - grant = first index i, scanning rr_ptr, rr_ptr+1, ... modulo NumFifos, with fifo_empty[i]=0.
  - out_valid = any FIFO non-empty. out_id = grant. out_data = fifo_pop_data[grant].
  - All outputs are combinational, giving zero-cycle latency from a non-empty flag to out_valid.
- HOLD state: grant = held_id and out_valid = 1, regardless of other FIFOs. The channel stays stable: valid, id and data do not change until accepted.
- Transfer: out_valid & out_ready sets fifo_pop[grant]=1 in the same cycle. Every other pop bit is 0.
- Stall: ARB with out_valid & !out_ready moves to HOLD and sets held_id <= grant. HOLD with out_ready returns to ARB after the transfer. HOLD with !out_ready stays in HOLD.
- Burst/pointer update, on transfer only:
  - If burst_cnt == MaxBurst-1: rr_ptr <= grant+1 (wrapping NumFifos-1 to 0) and burst_cnt <= 0.
  - Otherwise: rr_ptr <= grant and burst_cnt <= burst_cnt+1.
  - If the granted FIFO would go empty, indicated by fifo_empty being 0 now with no other data, the next cycle simply selects the next non-empty FIFO via the scan. burst_cnt is cleared whenever the next grant differs from the previous grant.
- No transfer means rr_ptr and burst_cnt are unchanged.
- Wrap-around: the index arithmetic is modulo NumFifos and must be correct for non-power-of-2 NumFifos (e.g. 3, 5).
- Boundaries:
  - All FIFOs empty in ARB gives out_valid=0 and no pops.
  - In HOLD, fifo_empty[held_id]=1 is a protocol violation and is asserted illegal.
  - Pushes into a FIFO while it is held do not change out_data, because the head is unchanged.
- Reset mid-HOLD: the next cycle after rst deasserts is ARB with rr_ptr=0. A transfer that was pending at reset is dropped.
- Fairness: any FIFO continuously non-empty is granted within (NumFifos-1)*MaxBurst transfers.
- Embedded assertions:
  - $onehot0(fifo_pop).
  - Never fifo_pop[i] & fifo_empty[i].
  - HOLD implies out_valid, with out_id and out_data stable until out_ready.
  - The fairness bound above.

Test Plan:
- NumFifos=4, MaxBurst=1, all FIFOs non-empty, out_ready=1 -> out_id sequence 0,1,2,3,0; one pop per cycle.
- Only FIFO 2 non-empty, rr_ptr=3 -> scan wraps; out_id=2 that cycle; rr_ptr becomes 3 after the pop.
- out_valid with out_ready=0 for 3 cycles while FIFO 0 becomes non-empty and rr_ptr=0 with grant=1 -> out_id stays 1 and data stays stable; no pops until out_ready=1, then pop[1] only.
- MaxBurst=2, FIFOs 0 and 1 each holding 3 entries -> out_id 0,0,1,1,0,1.
- rst asserted while in HOLD -> fifo_pop=0 and out_valid=0 immediately; after release, arbitration restarts at index 0.
- NumFifos=3, all non-empty for 9 transfers -> each FIFO popped exactly 3 times; the fairness assertion holds.
